// File: rtl/commit_unit_pkg.sv
// Shared types and constants for the in-order commit unit and its active list.
package commit_unit_pkg;

  localparam int DEF_REG_ADDR_WIDTH  = 5;
  localparam int DEF_FREE_LIST_WIDTH = 3;

  function automatic int depth_of(input int idx_w);
    return 1 << idx_w;
  endfunction

  localparam int DEPTH = depth_of(DEF_FREE_LIST_WIDTH);

  localparam logic [31:0] HEAD_RST = '0;
  localparam logic [31:0] TAIL_RST = '0;

  // Per-entry status bits; the address payload is kept beside it at module width.
  typedef struct packed {
    logic valid;
    logic done;
    logic wb_reg;
  } entry_flags_t;

  typedef struct packed {
    entry_flags_t                  flags;
    logic [DEF_REG_ADDR_WIDTH-1:0] vaddr;
    logic [DEF_REG_ADDR_WIDTH-1:0] paddr;
    logic [DEF_REG_ADDR_WIDTH-1:0] old_paddr;
  } entry_t;

endpackage

// File: rtl/commit_unit_active_list_ram.sv
// Active-list storage: alloc write port, done-set port, retire clear and async head read.
module active_list_ram
  import commit_unit_pkg::*;
#(
  parameter int AW = 5,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_wb_reg,
  input  logic [AW-1:0] wr_vaddr,
  input  logic [AW-1:0] wr_paddr,
  input  logic [AW-1:0] wr_old_paddr,
  input  logic          done_en,
  input  logic [IW-1:0] done_idx,
  input  logic          retire_en,
  input  logic [IW-1:0] head,
  output entry_flags_t  head_flags,
  output logic [AW-1:0] head_vaddr,
  output logic [AW-1:0] head_paddr,
  output logic [AW-1:0] head_old_paddr
);

  localparam int N = depth_of(IW);

  logic [N-1:0]         valid;
  logic [N-1:0]         done;
  logic [N-1:0]         wb_reg;
  logic [N-1:0][AW-1:0] vaddr;
  logic [N-1:0][AW-1:0] paddr;
  logic [N-1:0][AW-1:0] old_paddr;

  // Alloc never targets a live entry (tail is only live when full, and full refuses
  // alloc), so the three updates never collide on one index.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= '0;
      done  <= '0;
    end else begin
      if (done_en && valid[done_idx]) done[done_idx] <= 1'b1;
      if (retire_en) begin
        valid[head] <= 1'b0;
        done[head]  <= 1'b0;
      end
      if (wr_en) begin
        valid[wr_idx] <= 1'b1;
        done[wr_idx]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      wb_reg[wr_idx]    <= wr_wb_reg;
      vaddr[wr_idx]     <= wr_vaddr;
      paddr[wr_idx]     <= wr_paddr;
      old_paddr[wr_idx] <= wr_old_paddr;
    end
  end

  always_comb begin
    head_flags        = '0;
    head_flags.valid  = valid[head];
    head_flags.done   = done[head];
    head_flags.wb_reg = wb_reg[head];
    head_vaddr        = vaddr[head];
    head_paddr        = paddr[head];
    head_old_paddr    = old_paddr[head];
  end

endmodule

// File: rtl/commit_unit.sv
// In-order retirement of active-list entries; frees superseded physical registers.
// Optional COMMIT_BYPASS_EN lets a same-cycle completion of the head entry commit at once.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  output logic [FREE_LIST_WIDTH-1:0] alloc_index,
  input  logic                       alloc_wb_reg,
  input  logic [REG_ADDR_WIDTH-1:0]  alloc_virtual_addr,
  input  logic [REG_ADDR_WIDTH-1:0]  alloc_physical_addr,
  input  logic [REG_ADDR_WIDTH-1:0]  alloc_old_physical_addr,
  input  logic                       complete_valid,
  input  logic [FREE_LIST_WIDTH-1:0] complete_index,
  output logic                       commit_valid,
  output logic                       commit_wb_reg,
  output logic [REG_ADDR_WIDTH-1:0]  commit_virtual_addr,
  output logic [REG_ADDR_WIDTH-1:0]  commit_physical_addr,
  output logic                       free_valid,
  output logic [REG_ADDR_WIDTH-1:0]  free_physical_addr,
  output logic [FREE_LIST_WIDTH:0]   count
);

  localparam int IW = FREE_LIST_WIDTH;
  localparam int AW = REG_ADDR_WIDTH;

  if (DATA_WIDTH < 1 || AW < 1 || IW < 1) begin : g_bad_cfg
    $error("commit_unit: widths must be positive");
  end

  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [IW:0]   cnt;
  logic          clear;
  logic          alloc_fire;
  logic          head_done;
  entry_flags_t  head_flags;
  logic [AW-1:0] head_vaddr;
  logic [AW-1:0] head_paddr;
  logic [AW-1:0] head_old_paddr;

  assign clear       = !rst_n || flush;
  // Count never exceeds DEPTH, so its MSB alone marks full.
  assign alloc_ready = !cnt[IW];
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_index = tail;
  assign count       = cnt;

`ifdef COMMIT_BYPASS_EN
  assign head_done = head_flags.done || (complete_valid && complete_index == head);
`else
  assign head_done = head_flags.done;
`endif

  always_comb begin
    commit_valid         = head_flags.valid && head_done && !clear;
    commit_wb_reg        = 1'b0;
    commit_virtual_addr  = '0;
    commit_physical_addr = '0;
    free_valid           = 1'b0;
    free_physical_addr   = '0;
    if (commit_valid) begin
      commit_wb_reg        = head_flags.wb_reg;
      commit_virtual_addr  = head_vaddr;
      commit_physical_addr = head_paddr;
      free_valid           = head_flags.wb_reg;
      if (head_flags.wb_reg) free_physical_addr = head_old_paddr;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      head <= HEAD_RST[IW-1:0];
      tail <= TAIL_RST[IW-1:0];
      cnt  <= '0;
    end else begin
      if (alloc_fire)   tail <= tail + 1'b1;
      if (commit_valid) head <= head + 1'b1;
      cnt <= cnt + (IW+1)'(alloc_fire) - (IW+1)'(commit_valid);
    end
  end

  active_list_ram #(.AW(AW), .IW(IW)) u_ram (
    .clk            (clk),
    .clear          (clear),
    .wr_en          (alloc_fire),
    .wr_idx         (tail),
    .wr_wb_reg      (alloc_wb_reg),
    .wr_vaddr       (alloc_virtual_addr),
    .wr_paddr       (alloc_physical_addr),
    .wr_old_paddr   (alloc_old_physical_addr),
    .done_en        (complete_valid),
    .done_idx       (complete_index),
    .retire_en      (commit_valid),
    .head           (head),
    .head_flags     (head_flags),
    .head_vaddr     (head_vaddr),
    .head_paddr     (head_paddr),
    .head_old_paddr (head_old_paddr)
  );

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit; expectations follow COMMIT_BYPASS_EN if defined.
module tb_commit_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [2:0] alloc_index;
  logic       alloc_wb_reg;
  logic [4:0] alloc_virtual_addr;
  logic [4:0] alloc_physical_addr;
  logic [4:0] alloc_old_physical_addr;
  logic       complete_valid;
  logic [2:0] complete_index;
  logic       commit_valid;
  logic       commit_wb_reg;
  logic [4:0] commit_virtual_addr;
  logic [4:0] commit_physical_addr;
  logic       free_valid;
  logic [4:0] free_physical_addr;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  commit_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .FREE_LIST_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .alloc_wb_reg(alloc_wb_reg), .alloc_virtual_addr(alloc_virtual_addr),
    .alloc_physical_addr(alloc_physical_addr), .alloc_old_physical_addr(alloc_old_physical_addr),
    .complete_valid(complete_valid), .complete_index(complete_index),
    .commit_valid(commit_valid), .commit_wb_reg(commit_wb_reg),
    .commit_virtual_addr(commit_virtual_addr), .commit_physical_addr(commit_physical_addr),
    .free_valid(free_valid), .free_physical_addr(free_physical_addr), .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; alloc_wb_reg = 0; alloc_virtual_addr = 0;
    alloc_physical_addr = 0; alloc_old_physical_addr = 0;
    complete_valid = 0; complete_index = 0;
  endtask

  task automatic drive_alloc(input logic wb, input logic [4:0] va, input logic [4:0] pa,
                             input logic [4:0] opa);
    alloc_valid = 1; alloc_wb_reg = wb; alloc_virtual_addr = va;
    alloc_physical_addr = pa; alloc_old_physical_addr = opa;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #1;
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%0b exp=1", alloc_ready); end
    total++; if (alloc_index !== 3'd0) begin bad++; $display("FAIL reset_alloc_index got=%0d exp=0", alloc_index); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({commit_valid, free_valid, commit_wb_reg} !== 3'b000) begin bad++; $display("FAIL reset_commit_flags got=%b exp=000", {commit_valid, free_valid, commit_wb_reg}); end
    total++; if ({commit_virtual_addr, commit_physical_addr, free_physical_addr} !== 15'd0) begin bad++; $display("FAIL reset_addrs got=%h exp=0", {commit_virtual_addr, commit_physical_addr, free_physical_addr}); end
  endtask

  task automatic test_in_order();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(1'b1, 5'(i + 1), 5'(i + 17), 5'(i + 9));
      #1;
      total++; if (alloc_index !== 3'(i)) begin bad++; $display("FAIL inord_alloc_index got=%0d exp=%0d", alloc_index, i); end
      tick();
    end
    idle();
    #1;
    total++; if (count !== 4'd3) begin bad++; $display("FAIL inord_count got=%0d exp=3", count); end
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL inord_no_commit got=%0b exp=0", commit_valid); end
    for (int k = 2; k >= 1; k--) begin
      complete_valid = 1; complete_index = 3'(k);
      #1;
      total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL inord_wait_head%0d got=%0b exp=0", k, commit_valid); end
      tick();
    end
    complete_valid = 1; complete_index = 3'd0;
    #1;
`ifdef COMMIT_BYPASS_EN
    total++; if (commit_valid !== 1'b1 || free_physical_addr !== 5'd9) begin bad++; $display("FAIL inord_bypass got=%0b/%0d exp=1/9", commit_valid, free_physical_addr); end
    tick();
    complete_valid = 0;
    for (int k = 1; k < 3; k++) begin
`else
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL inord_no_bypass got=%0b exp=0", commit_valid); end
    tick();
    complete_valid = 0;
    for (int k = 0; k < 3; k++) begin
`endif
      #1;
      total++;
      if (commit_valid !== 1'b1 || free_valid !== 1'b1 || free_physical_addr !== 5'(9 + k) ||
          commit_virtual_addr !== 5'(k + 1) || commit_physical_addr !== 5'(k + 17)) begin
        bad++;
        $display("FAIL inord_commit%0d got=v%0b f%0b fa%0d va%0d pa%0d exp=v1 f1 fa%0d va%0d pa%0d",
                 k, commit_valid, free_valid, free_physical_addr, commit_virtual_addr,
                 commit_physical_addr, 9 + k, k + 1, k + 17);
      end
      tick();
    end
    #1;
    total++; if (commit_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL inord_drained got=%0b/%0d exp=0/0", commit_valid, count); end
  endtask

  task automatic test_full();
    // head = tail = 3 here, so filling wraps the tail through 7 -> 0
    for (int i = 0; i < 8; i++) begin
      drive_alloc(1'b1, 5'(i), 5'(i + 8), 5'(i + 20));
      #1;
      total++; if (alloc_index !== 3'((3 + i) % 8) || alloc_ready !== 1'b1) begin bad++; $display("FAIL full_fill%0d got=%0d/%0b exp=%0d/1", i, alloc_index, alloc_ready, (3 + i) % 8); end
      tick();
    end
    drive_alloc(1'b1, 5'd31, 5'd31, 5'd31);
    #1;
    total++; if (alloc_ready !== 1'b0 || count !== 4'd8) begin bad++; $display("FAIL full_flag got=%0b/%0d exp=0/8", alloc_ready, count); end
    tick();
    total++; if (count !== 4'd8 || alloc_index !== 3'd3) begin bad++; $display("FAIL full_ninth got=%0d/%0d exp=8/3", count, alloc_index); end
    complete_valid = 1; complete_index = 3'd3;
    #1;
`ifndef COMMIT_BYPASS_EN
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL full_wait got=%0b exp=0", commit_valid); end
    tick();
    complete_valid = 0;
    #1;
`endif
    total++; if (commit_valid !== 1'b1 || alloc_ready !== 1'b0 || free_physical_addr !== 5'd20) begin bad++; $display("FAIL full_commit got=%0b/%0b/%0d exp=1/0/20", commit_valid, alloc_ready, free_physical_addr); end
    tick();
    complete_valid = 0;
    drive_alloc(1'b1, 5'd30, 5'd29, 5'd28);
    #1;
    total++; if (count !== 4'd7 || alloc_ready !== 1'b1 || alloc_index !== 3'd3) begin bad++; $display("FAIL full_reopen got=%0d/%0b/%0d exp=7/1/3", count, alloc_ready, alloc_index); end
    tick();
    idle();
    #1;
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_refill got=%0d exp=8", count); end
  endtask

  task automatic test_flush();
    flush = 1;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      drive_alloc(1'b1, 5'(i), 5'(i), 5'(i));
      tick();
    end
    idle();
    flush = 1; complete_valid = 1; complete_index = 3'd0;
    #1;
    total++; if (commit_valid !== 1'b0 || free_valid !== 1'b0) begin bad++; $display("FAIL flush_gate got=%0b/%0b exp=0/0", commit_valid, free_valid); end
    tick();
    idle();
    #1;
    total++; if (count !== 4'd0 || alloc_index !== 3'd0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL flush_state got=%0d/%0d/%0b exp=0/0/1", count, alloc_index, alloc_ready); end
    drive_alloc(1'b1, 5'd1, 5'd1, 5'd1);
    tick();
    idle();
    #1;
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL flush_done_cleared got=%0b exp=0", commit_valid); end
  endtask

  task automatic test_no_wb();
    flush = 1;
    tick();
    idle();
    drive_alloc(1'b0, 5'd7, 5'd20, 5'd21);
    tick();
    idle();
    complete_valid = 1; complete_index = 3'd0;
`ifndef COMMIT_BYPASS_EN
    tick();
    complete_valid = 0;
`endif
    #1;
    total++;
    if (commit_valid !== 1'b1 || commit_wb_reg !== 1'b0 || free_valid !== 1'b0 ||
        free_physical_addr !== 5'd0 || commit_virtual_addr !== 5'd7 || commit_physical_addr !== 5'd20) begin
      bad++;
      $display("FAIL nowb got=v%0b w%0b f%0b fa%0d va%0d pa%0d exp=v1 w0 f0 fa0 va7 pa20",
               commit_valid, commit_wb_reg, free_valid, free_physical_addr, commit_virtual_addr, commit_physical_addr);
    end
    tick();
    idle();
  endtask

  task automatic test_invalid_complete();
    // head = tail = 1: index 1 is empty, so this completion must not stick
    complete_valid = 1; complete_index = 3'd1;
    tick();
    idle();
    drive_alloc(1'b1, 5'd4, 5'd5, 5'd6);
    tick();
    idle();
    #1;
    total++; if (commit_valid !== 1'b0 || count !== 4'd1) begin bad++; $display("FAIL invalid_complete got=%0b/%0d exp=0/1", commit_valid, count); end
  endtask

  task automatic test_reset_mid();
    complete_valid = 1; complete_index = 3'd1;
`ifndef COMMIT_BYPASS_EN
    tick();
    complete_valid = 0;
`endif
    rst_n = 0;
    #1;
    total++; if (commit_valid !== 1'b0 || free_valid !== 1'b0) begin bad++; $display("FAIL midrst_gate got=%0b/%0b exp=0/0", commit_valid, free_valid); end
    tick();
    rst_n = 1;
    idle();
    #1;
    total++; if (count !== 4'd0 || alloc_index !== 3'd0 || commit_valid !== 1'b0) begin bad++; $display("FAIL midrst_state got=%0d/%0d/%0b exp=0/0/0", count, alloc_index, commit_valid); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_flush();
    test_no_wb();
    test_invalid_complete();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
# commit_unit

In-order retirement block at the far end of the writeback stage in the renamed pipeline. The rename stage allocates one active-list entry per instruction, and the entry's index travels down the pipeline. The MEM→WB register delivers that index back here when the result is written. The block retires completed entries strictly in program order and returns each superseded physical register to the free list.

## Interface
Parameters:
- DATA_WIDTH, 32: datapath width (unused internally; kept for uniform instantiation)
- REG_ADDR_WIDTH, 5: virtual/physical register address width
- FREE_LIST_WIDTH, 3: active-list index width; DEPTH = 2**FREE_LIST_WIDTH entries

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; one clock, synchronous, active-low
- flush  in  1  discard all entries (mispredict/exception recovery)
- alloc_valid  in  1  rename stage allocates an entry this cycle
- alloc_ready  out  1  entry available (count < DEPTH)
- alloc_index  out  FREE_LIST_WIDTH  index granted (= tail)
- alloc_wb_reg  in  1  instruction writes a register
- alloc_virtual_addr  in  REG_ADDR_WIDTH  destination virtual register
- alloc_physical_addr  in  REG_ADDR_WIDTH  newly mapped physical register
- alloc_old_physical_addr  in  REG_ADDR_WIDTH  previous mapping, freed on commit
- complete_valid  in  1  writeback finished for an entry
- complete_index  in  FREE_LIST_WIDTH  active_list_index from MEM→WB
- commit_valid  out  1  head entry retires this cycle
- commit_wb_reg  out  1  retiring entry writes a register
- commit_virtual_addr  out  REG_ADDR_WIDTH  architectural map update address
- commit_physical_addr  out  REG_ADDR_WIDTH  architectural map update value
- free_valid  out  1  return free_physical_addr to the free list
- free_physical_addr  out  REG_ADDR_WIDTH  released physical register
- count  out  FREE_LIST_WIDTH+1  occupied entries

## Operation
- State:
  - circular buffer of DEPTH entries, each {valid, done, wb_reg, vaddr, paddr, old_paddr}
  - head and tail pointers, FREE_LIST_WIDTH bits, wrap modulo DEPTH
  - count register
- Allocate: when alloc_valid && alloc_ready, write entry[tail] with valid=1, done=0; tail+1.
  - alloc_valid while !alloc_ready is ignored; no state change.
- Complete: when complete_valid && entry[complete_index].valid, set done=1.
  - An index naming an invalid entry is ignored.
  - A repeat completion is harmless.
- Commit: commit_valid = entry[head].valid && entry[head].done && !flush.
  - On commit: clear entry[head].valid; head+1.
  - free_valid = commit_valid && commit_wb_reg, with free_physical_addr = old_paddr.
- Commit outputs are combinational from head-entry state; the other fields are 0 when commit_valid is 0.
- count updates as +alloc −commit each cycle. Simultaneous alloc and commit leave count unchanged.
- alloc_ready is computed from registered count only. When full, alloc is refused even if a commit happens in the same cycle.
- Flush (priority over alloc/complete/commit): clear all valid/done bits, head=tail=0, count=0.
- Reset (rst_n low at posedge): same as flush.
  - Resulting outputs: alloc_ready=1, alloc_index=0, count=0, commit_valid=0, free_valid=0, all address outputs 0.

## Timing
- Alloc → earliest commit: alloc at edge N, complete at edge N+1, commit_valid high in cycle N+1→N+2, head advances at edge N+2.
- Completion is registered; commit is seen the cycle after complete_valid (without COMMIT_BYPASS_EN).
- Throughput: one alloc, one complete and one commit per cycle.
- Reset asserted mid-operation discards everything at that edge; no commit or free is emitted in that cycle.

## Configuration
- COMMIT_BYPASS_EN defined:
  - A complete_valid whose complete_index == head is also treated as done for the commit check in the same cycle.
  - Saves one cycle of latency.
- COMMIT_BYPASS_EN undefined: commit only observes the registered done bit.

## Structure
- Shared package: active-list entry struct/typedef, DEPTH constant, reset constants for pointers.
- Natural sub-module: active_list_ram, the DEPTH-entry storage with one write port for alloc, a done-bit set port, and an asynchronous head read port.

## Test plan
- Reset, then alloc 3 entries (vaddr 1,2,3; old paddr 9,10,11): alloc_index 0,1,2 and count=3; no commit until completion.
- Complete indices 2,1,0 out of order: commits occur in order 0,1,2 only after index 0 completes; free_physical_addr emits 9,10,11.
- Fill 8 entries: alloc_ready=0 and a 9th alloc is ignored. Commit one, then alloc: tail wraps and alloc_index=0.
- Entry with alloc_wb_reg=0 completes: commit_valid=1, free_valid=0.
- Flush with 5 entries, index 0 completing in the same cycle: no commit that cycle; next cycle count=0, alloc_index=0.
- With COMMIT_BYPASS_EN: complete head at edge N gives commit_valid in the same cycle as complete_valid. Without it, commit_valid appears one cycle later.
